// File: rtl/jj_pkg.sv
// jj_pkg: types and constants shared by the obstacle scheduler and the animator.
package jj_pkg;
   typedef enum logic [1:0] {OBS_FLAT, OBS_TALL, OBS_TRI_FALL, OBS_TRI_RISE} obs_type_t;
   typedef enum logic [1:0] {POS_TOP, POS_MID, POS_BOT} obs_pos_t;
   typedef enum logic [1:0] {IDLE, RUN, HALT} sched_state_t;
   // x values carry the animator's -100 offset: 740 lands on the right screen edge
   localparam logic [9:0]  SPAWN_X      = 10'd740;
   localparam logic [9:0]  PARK_X       = 10'd1000;
   localparam logic [3:0]  SPEED_INIT   = 4'd2;
   localparam logic [3:0]  SPEED_MAX    = 4'd8;
   localparam int          SPEED_STEP   = 600;
   localparam int          GAP_MIN      = 60;
   localparam int          FLICK_FRAMES = 8;
   localparam logic [15:0] LFSR_SEED    = 16'hACE1;
   function automatic obs_pos_t remap_pos(input logic [1:0] r);
      return (r == 2'b11) ? POS_MID : obs_pos_t'(r);
   endfunction
endpackage

// File: rtl/obstacle_slot.sv
// obstacle_slot: one obstacle; loads on spawn, scrolls left each tick, retires past the left edge.
module obstacle_slot
   import jj_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tick,
   input  logic       spawn,
   input  logic [3:0] speed,
   input  logic [3:0] rnd,
   output logic       active,
   output logic [9:0] x,
   output obs_type_t  kind,
   output obs_pos_t   pos,
   output logic       flick
);
   localparam int FW = $clog2(FLICK_FRAMES);
   localparam logic [FW-1:0] FLAST = FW'(FLICK_FRAMES - 1);
   logic [FW-1:0] fcnt;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         active <= 1'b0;
         x      <= PARK_X;
         kind   <= OBS_FLAT;
         pos    <= POS_TOP;
         flick  <= 1'b0;
         fcnt   <= '0;
      end else if (spawn) begin
         active <= 1'b1;
         x      <= SPAWN_X;
         kind   <= obs_type_t'(rnd[1:0]);
         pos    <= remap_pos(rnd[3:2]);
         fcnt   <= '0;
      end else if (tick && active) begin
         if (x >= {6'd0, speed}) begin
            x     <= x - {6'd0, speed};
            fcnt  <= (fcnt == FLAST) ? '0 : fcnt + 1'b1;
            flick <= (fcnt == FLAST) ? ~flick : flick;
         end else begin
            active <= 1'b0;
            x      <= PARK_X;
            flick  <= 1'b0;
            fcnt   <= '0;
         end
      end
endmodule

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: per-frame spawn/scroll/retire control of two obstacle slots,
// with speed ramp, score and scene freeze on collision.
module obstacle_scheduler
   import jj_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        frame_tick,
   input  logic        start,
   input  logic        game_over,
   output logic [1:0]  obs1_type,
   output logic [1:0]  obs2_type,
   output logic [1:0]  obs1_pos,
   output logic [1:0]  obs2_pos,
   output logic [9:0]  obs1_x,
   output logic [9:0]  obs2_x,
   output logic        obs1_active,
   output logic        obs2_active,
   output logic        flick1,
   output logic        flick2,
   output logic [3:0]  speed,
   output logic [15:0] score,
   output logic        running
);
   localparam logic [9:0] STEP_LAST = 10'(SPEED_STEP - 1);
   sched_state_t state, state_nx;
   logic [15:0] lfsr;
   logic [7:0]  gap;
   logic [9:0]  step;
   logic        ptr, tick, due;
   logic [1:0]  spawn;
   obs_type_t   kind1, kind2;
   obs_pos_t    pos1, pos2;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nx;
   always_comb
      state_nx = (state == IDLE && start) ? RUN :
                 (state == RUN && game_over) ? HALT : state;
   always_comb
      running = (state == RUN);
   // a collision frame outranks its own tick, so the scene freezes exactly as last drawn
   assign tick  = (state == RUN) && frame_tick && !game_over;
   assign due   = tick && (gap == 8'd0);
   assign spawn = {due && ptr && !obs2_active, due && !ptr && !obs1_active};
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) lfsr <= LFSR_SEED;
      else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         gap   <= 8'(GAP_MIN);
         step  <= '0;
         speed <= SPEED_INIT;
         score <= '0;
         ptr   <= 1'b0;
      end else if (tick) begin
         if (gap != 8'd0) gap <= gap - 1'b1;
         else if (|spawn) begin
            gap <= 8'(GAP_MIN) + {2'b00, lfsr[5:4], 4'b0000};
            ptr <= ~ptr;
         end
         step  <= (step == STEP_LAST) ? '0 : step + 1'b1;
         speed <= (step == STEP_LAST && speed < SPEED_MAX) ? speed + 1'b1 : speed;
         score <= (score == 16'hFFFF) ? score : score + 1'b1;
      end
   obstacle_slot u_slot1 (
      .clk    (clk),
      .reset_n(reset_n),
      .tick   (tick),
      .spawn  (spawn[0]),
      .speed  (speed),
      .rnd    (lfsr[3:0]),
      .active (obs1_active),
      .x      (obs1_x),
      .kind   (kind1),
      .pos    (pos1),
      .flick  (flick1)
   );
   obstacle_slot u_slot2 (
      .clk    (clk),
      .reset_n(reset_n),
      .tick   (tick),
      .spawn  (spawn[1]),
      .speed  (speed),
      .rnd    (lfsr[3:0]),
      .active (obs2_active),
      .x      (obs2_x),
      .kind   (kind2),
      .pos    (pos2),
      .flick  (flick2)
   );
   assign obs1_type = kind1;
   assign obs2_type = kind2;
   assign obs1_pos  = pos1;
   assign obs2_pos  = pos2;
endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler: opening-sequence vector table, randomized play against a
// tick-count reference model, collision freeze and asynchronous reset sequences.
module tb_obstacle_scheduler;
   logic clk = 1'b0;
   logic reset_n = 1'b0, frame_tick = 1'b0, start = 1'b0, game_over = 1'b0;
   logic [1:0]  obs1_type, obs2_type, obs1_pos, obs2_pos;
   logic [9:0]  obs1_x, obs2_x;
   logic        obs1_active, obs2_active, flick1, flick2, running;
   logic [3:0]  speed;
   logic [15:0] score;
   int n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   obstacle_scheduler dut (
      .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .start(start), .game_over(game_over),
      .obs1_type(obs1_type), .obs2_type(obs2_type), .obs1_pos(obs1_pos), .obs2_pos(obs2_pos),
      .obs1_x(obs1_x), .obs2_x(obs2_x), .obs1_active(obs1_active), .obs2_active(obs2_active),
      .flick1(flick1), .flick2(flick2), .speed(speed), .score(score), .running(running)
   );

   logic       ga[2], gf[2];
   logic [9:0] gx[2];
   logic [1:0] gk[2], gp[2];
   assign ga[0] = obs1_active;
   assign ga[1] = obs2_active;
   assign gf[0] = flick1;
   assign gf[1] = flick2;
   assign gx[0] = obs1_x;
   assign gx[1] = obs2_x;
   assign gk[0] = obs1_type;
   assign gk[1] = obs2_type;
   assign gp[0] = obs1_pos;
   assign gp[1] = obs2_pos;

   // Reference model: the scene as a function of ticks played (m_n); speed, score and flick
   // are derived arithmetically from tick counts, spawns from the tick number they become due.
   int m_st, m_n, m_next, m_ptr;
   logic [15:0] m_lfsr;
   int m_act[2], m_x[2], m_kind[2], m_pos[2], m_age[2];

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   function automatic int speed_at(input int n);
      return (2 + n / 600 > 8) ? 8 : 2 + n / 600;
   endfunction

   task automatic model_tick();
      int sp = speed_at(m_n);
      bit do_spawn = (m_n + 1 >= m_next) && (m_act[m_ptr] == 0);
      m_n++;
      for (int i = 0; i < 2; i++)
         if (m_act[i] != 0) begin
            if (m_x[i] >= sp) begin
               m_x[i] -= sp;
               m_age[i]++;
            end else begin
               m_act[i] = 0;
               m_x[i] = 1000;
               m_age[i] = 0;
            end
         end
      if (do_spawn) begin
         m_act[m_ptr]  = 1;
         m_x[m_ptr]    = 740;
         m_kind[m_ptr] = int'(m_lfsr[1:0]);
         m_pos[m_ptr]  = (m_lfsr[3:2] == 2'b11) ? 1 : int'(m_lfsr[3:2]);
         m_age[m_ptr]  = 0;
         m_next = m_n + 1 + 60 + 16 * int'(m_lfsr[5:4]);
         m_ptr = 1 - m_ptr;
      end
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_st = 0;
         m_n = 0;
         m_next = 61;
         m_ptr = 0;
         m_lfsr = 16'hACE1;
         for (int i = 0; i < 2; i++) begin
            m_act[i] = 0;
            m_x[i] = 1000;
            m_kind[i] = 0;
            m_pos[i] = 0;
            m_age[i] = 0;
         end
      end else begin
         if (m_st == 1 && game_over) m_st = 2;
         else if (m_st == 1 && frame_tick) model_tick();
         else if (m_st == 0 && start) m_st = 1;
         m_lfsr = lfsr_next(m_lfsr);
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   task automatic chk_all();
      chk("running", 32'(running), 32'(m_st == 1));
      chk("speed", 32'(speed), speed_at(m_n));
      chk("score", 32'(score), (m_n > 65535) ? 65535 : m_n);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("obs%0d_active", i + 1), 32'(ga[i]), m_act[i]);
         chk($sformatf("obs%0d_x", i + 1), 32'(gx[i]), m_x[i]);
         chk($sformatf("obs%0d_type", i + 1), 32'(gk[i]), m_kind[i]);
         chk($sformatf("obs%0d_pos", i + 1), 32'(gp[i]), m_pos[i]);
         chk($sformatf("flick%0d", i + 1), 32'(gf[i]), (m_act[i] != 0) ? (m_age[i] / 8) % 2 : 0);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_running"}, 32'(running), 0);
      chk({tag, "_speed"}, 32'(speed), 2);
      chk({tag, "_score"}, 32'(score), 0);
      chk({tag, "_obs1_x"}, 32'(obs1_x), 1000);
      chk({tag, "_obs2_x"}, 32'(obs2_x), 1000);
      chk({tag, "_active"}, 32'({obs1_active, obs2_active}), 0);
      chk({tag, "_type"}, 32'({obs1_type, obs2_type}), 0);
      chk({tag, "_pos"}, 32'({obs1_pos, obs2_pos}), 0);
      chk({tag, "_flick"}, 32'({flick1, flick2}), 0);
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_tick();
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      cyc($urandom_range(0, 1));
   endtask

   task automatic run_ticks(input int n);
      for (int k = 0; k < n; k++) begin
         start = ($urandom_range(0, 15) == 0);
         do_tick();
         chk_all();
      end
      start = 1'b0;
   endtask

   typedef struct {
      logic st;
      int   nt;
      logic run;
      logic a1;
      int   x1;
      int   sp;
      int   sc;
   } vec_t;
   vec_t tbl[6];

   initial begin
      tbl[0] = '{1'b0, 5,  1'b0, 1'b0, 1000, 2, 0};
      tbl[1] = '{1'b1, 0,  1'b1, 1'b0, 1000, 2, 0};
      tbl[2] = '{1'b0, 60, 1'b1, 1'b0, 1000, 2, 60};
      tbl[3] = '{1'b0, 1,  1'b1, 1'b1, 740,  2, 61};
      tbl[4] = '{1'b0, 1,  1'b1, 1'b1, 738,  2, 62};
      tbl[5] = '{1'b1, 3,  1'b1, 1'b1, 732,  2, 65};
      cyc(3);
      @(negedge clk);
      reset_n = 1'b1;
      cyc(1);
      chk_reset("por");
      for (int v = 0; v < 6; v++) begin
         start = tbl[v].st;
         if (tbl[v].nt == 0) cyc(1);
         else for (int k = 0; k < tbl[v].nt; k++) do_tick();
         start = 1'b0;
         chk($sformatf("vec%0d_running", v), 32'(running), 32'(tbl[v].run));
         chk($sformatf("vec%0d_obs1_active", v), 32'(obs1_active), 32'(tbl[v].a1));
         chk($sformatf("vec%0d_obs1_x", v), 32'(obs1_x), tbl[v].x1);
         chk($sformatf("vec%0d_speed", v), 32'(speed), tbl[v].sp);
         chk($sformatf("vec%0d_score", v), 32'(score), tbl[v].sc);
         chk_all();
      end
      run_ticks(20000);
      chk("speed_saturated", 32'(speed), 8);
      // asynchronous reset between edges, then idle ticks must not wake the scene
      #2 reset_n = 1'b0;
      #1 chk_reset("async");
      cyc(2);
      @(negedge clk);
      reset_n = 1'b1;
      cyc(1);
      for (int k = 0; k < 3; k++) do_tick();
      chk_reset("idle_after_reset");
      chk_all();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      chk("restart_running", 32'(running), 1);
      chk_all();
      run_ticks(5000);
      // collision on a tick: no movement, spawn or score change, then frozen for good
      frame_tick = 1'b1;
      game_over = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      game_over = 1'b0;
      chk("halt_running", 32'(running), 0);
      chk_all();
      run_ticks(100);
      chk("halt_score", 32'(score), (m_n > 65535) ? 65535 : m_n);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
